// File: rtl/spi_frame_loader.sv
// Framed SPI byte-stream parser: turns grid and move sections into register-file
// writes for the TPU, with frame-boundary detection and error reporting.
module spi_frame_loader #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MOVE_WIDTH = 16,
    parameter int MAX_MOVES  = 220,
    parameter logic [DATA_WIDTH-1:0] GRID_HEADER = 8'b11_01_01_01,
    parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = 8'b11_10_10_10
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               spi_iv,
    input  logic [DATA_WIDTH-1:0]              spi_id,
    output logic                               grid_we,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]    grid_waddr,
    output logic [DATA_WIDTH-1:0]              grid_wdata,
    output logic                               move_we,
    output logic [$clog2(MAX_MOVES)-1:0]       move_waddr,
    output logic [MOVE_WIDTH-1:0]              move_wdata,
    output logic                               grid_done,
    output logic                               moves_done,
    output logic [$clog2(MAX_MOVES+1)-1:0]     move_count,
    output logic                               busy,
    output logic                               err,
    output logic [1:0]                         err_code
);

    localparam int NSQ = WIDTH * HEIGHT;
    localparam int BPM = MOVE_WIDTH / DATA_WIDTH;
    localparam int GAW = $clog2(NSQ);
    localparam int MAW = $clog2(MAX_MOVES);
    localparam int MCW = $clog2(MAX_MOVES + 1);
    localparam int BCW = (BPM > 1) ? $clog2(BPM) : 1;

    localparam logic [GAW-1:0] LAST_SQ = GAW'(NSQ - 1);
    localparam logic [BCW-1:0] LAST_B  = BCW'(BPM - 1);
    localparam logic [MCW-1:0] MAX_MC  = MCW'(MAX_MOVES);

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_HDR   = 2'd1;
    localparam logic [1:0] E_SHORT = 2'd2;
    localparam logic [1:0] E_OVF   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRID,
        S_MOVES,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic                   iv_q;
    logic [GAW-1:0]         sq_cnt_q, sq_cnt_d;
    logic [BCW-1:0]         b_cnt_q, b_cnt_d;
    logic [MOVE_WIDTH-1:0]  asm_q, asm_d;

    logic                   grid_we_q, grid_we_d;
    logic [GAW-1:0]         grid_waddr_q, grid_waddr_d;
    logic [DATA_WIDTH-1:0]  grid_wdata_q, grid_wdata_d;
    logic                   move_we_q, move_we_d;
    logic [MAW-1:0]         move_waddr_q, move_waddr_d;
    logic [MOVE_WIDTH-1:0]  move_wdata_q, move_wdata_d;
    logic                   grid_done_q, grid_done_d;
    logic                   moves_done_q, moves_done_d;
    logic [MCW-1:0]         move_count_q, move_count_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [MOVE_WIDTH-1:0]  shifted;

    always_comb begin
        state_d      = state_q;
        sq_cnt_d     = sq_cnt_q;
        b_cnt_d      = b_cnt_q;
        asm_d        = asm_q;
        shifted      = MOVE_WIDTH'({asm_q, spi_id});
        grid_we_d    = 1'b0;
        grid_waddr_d = grid_waddr_q;
        grid_wdata_d = grid_wdata_q;
        move_we_d    = 1'b0;
        move_waddr_d = move_waddr_q;
        move_wdata_d = move_wdata_q;
        grid_done_d  = 1'b0;
        moves_done_d = 1'b0;
        move_count_d = move_count_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        // The first byte after a gap starts a new frame and wipes the previous report.
        if (spi_iv && !iv_q) begin
            err_d      = 1'b0;
            err_code_d = E_NONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (spi_iv) begin
                    if (spi_id == GRID_HEADER) begin
                        state_d  = S_GRID;
                        sq_cnt_d = '0;
                    end else if (spi_id == MOVE_HEADER) begin
                        state_d      = S_MOVES;
                        move_count_d = '0;
                        b_cnt_d      = '0;
                    end else begin
                        state_d    = S_DRAIN;
                        err_d      = 1'b1;
                        err_code_d = E_HDR;
                    end
                end
            end
            S_GRID: begin
                if (spi_iv) begin
                    grid_we_d    = 1'b1;
                    grid_waddr_d = sq_cnt_q;
                    grid_wdata_d = spi_id;
                    sq_cnt_d     = sq_cnt_q + 1'b1;
                    if (sq_cnt_q == LAST_SQ) begin
                        grid_done_d = 1'b1;
                        sq_cnt_d    = '0;
                        state_d     = S_IDLE;
                    end
                end else begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = E_SHORT;
                end
            end
            S_MOVES: begin
                if (spi_iv) begin
                    asm_d   = shifted;
                    b_cnt_d = b_cnt_q + 1'b1;
                    if (b_cnt_q == LAST_B) begin
                        b_cnt_d = '0;
                        if (move_count_q < MAX_MC) begin
                            move_we_d    = 1'b1;
                            move_waddr_d = move_count_q[MAW-1:0];
                            move_wdata_d = shifted;
                            move_count_d = move_count_q + 1'b1;
                        end else begin
                            state_d    = S_DRAIN;
                            err_d      = 1'b1;
                            err_code_d = E_OVF;
                        end
                    end
                end else begin
                    // Section closes on the gap; a half-built move is dropped, not written.
                    moves_done_d = 1'b1;
                    state_d      = S_IDLE;
                    if (b_cnt_q != '0) begin
                        err_d      = 1'b1;
                        err_code_d = E_SHORT;
                    end
                end
            end
            S_DRAIN: begin
                if (!spi_iv) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            iv_q         <= 1'b0;
            sq_cnt_q     <= '0;
            b_cnt_q      <= '0;
            asm_q        <= '0;
            grid_we_q    <= 1'b0;
            grid_waddr_q <= '0;
            grid_wdata_q <= '0;
            move_we_q    <= 1'b0;
            move_waddr_q <= '0;
            move_wdata_q <= '0;
            grid_done_q  <= 1'b0;
            moves_done_q <= 1'b0;
            move_count_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= E_NONE;
        end else begin
            state_q      <= state_d;
            iv_q         <= spi_iv;
            sq_cnt_q     <= sq_cnt_d;
            b_cnt_q      <= b_cnt_d;
            asm_q        <= asm_d;
            grid_we_q    <= grid_we_d;
            grid_waddr_q <= grid_waddr_d;
            grid_wdata_q <= grid_wdata_d;
            move_we_q    <= move_we_d;
            move_waddr_q <= move_waddr_d;
            move_wdata_q <= move_wdata_d;
            grid_done_q  <= grid_done_d;
            moves_done_q <= moves_done_d;
            move_count_q <= move_count_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign grid_we    = grid_we_q;
    assign grid_waddr = grid_waddr_q;
    assign grid_wdata = grid_wdata_q;
    assign move_we    = move_we_q;
    assign move_waddr = move_waddr_q;
    assign move_wdata = move_wdata_q;
    assign grid_done  = grid_done_q;
    assign moves_done = moves_done_q;
    assign move_count = move_count_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Byte-stream front end for the TPU. Parses framed SPI input (`spi_iv`/`spi_id`) into board-square writes for the grid memory and packed move words for the move buffer.
- Generalises the fixed 8x8 / 16-bit-move load path:
  - board size and move width are parametrised;
  - moves are assembled from multiple bytes;
  - frame boundaries are detected;
  - short, malformed and overflowing frames are reported with error codes.
- Sits between the SPI slave and the TPU register files. Its done pulses start the TPU program.

Parameters:
- WIDTH, 8, board columns.
- HEIGHT, 8, board rows. NSQ = WIDTH*HEIGHT.
- DATA_WIDTH, 8, SPI byte width.
- MOVE_WIDTH, 16, move word width. Must be an integer multiple of DATA_WIDTH. BPM = MOVE_WIDTH/DATA_WIDTH.
- MAX_MOVES, 220, move buffer depth.
- GRID_HEADER, 8'b11_01_01_01, header byte that opens a grid section.
- MOVE_HEADER, 8'b11_10_10_10, header byte that opens a move section.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- spi_iv  in  1  byte valid. A contiguous high run is one frame; a low cycle ends the frame.
- spi_id  in  DATA_WIDTH  byte data.
- grid_we  out  1  grid square write strobe.
- grid_waddr  out  $clog2(NSQ)  square index, 0..NSQ-1.
- grid_wdata  out  DATA_WIDTH  square value.
- move_we  out  1  move write strobe.
- move_waddr  out  $clog2(MAX_MOVES)  move index.
- move_wdata  out  MOVE_WIDTH  assembled move. First received byte is the MSB.
- grid_done  out  1  one-cycle pulse: all NSQ squares written.
- moves_done  out  1  one-cycle pulse: move section closed.
- move_count  out  $clog2(MAX_MOVES+1)  moves written in the last/current move section.
- busy  out  1  state != IDLE.
- err  out  1  sticky error flag.
- err_code  out  2  error code: 0 none, 1 bad header, 2 short (grid or partial move), 3 move overflow.

Behaviour:
- Reset (async, nrst=0): all outputs 0, state IDLE, all counters 0. Any in-progress section is discarded; nothing already written is rewritten.
- A byte is accepted on a rising edge with spi_iv=1.
- All outputs are registered. A write strobe appears the cycle after its last contributing byte is accepted.
- State IDLE, on each accepted byte:
  - GRID_HEADER → GRID; square counter := 0.
  - MOVE_HEADER → MOVES; move_count := 0; byte counter := 0.
  - Any other byte → err=1, err_code=1, → DRAIN.
- err/err_code clear when the first byte of a new frame is accepted (the byte following a spi_iv=0 cycle), before that byte is decoded.
- State GRID:
  - Each accepted byte issues grid_we=1, grid_waddr=counter, grid_wdata=byte; counter increments.
  - On the NSQ-th byte: grid_done=1 in the same cycle as that byte's write, then → IDLE. The frame may continue with another header.
  - spi_iv=0 before NSQ bytes: err_code=2, no grid_done, → IDLE.
- State MOVES:
  - Bytes shift into an MSB-first assembly register.
  - On the BPM-th byte: if move_count < MAX_MOVES, issue move_we, move_waddr=move_count, move_count++.
  - Otherwise: err_code=3, → DRAIN. No write is issued.
  - Byte counter wraps to 0 after each completed move.
- Move section close, on the first cycle with spi_iv=0 while in MOVES: moves_done pulses on the next edge and the state returns to IDLE.
  - A partially assembled move (byte counter != 0) is discarded and sets err_code=2.
  - moves_done still fires; move_count reflects complete moves only.
- State DRAIN: ignores bytes until spi_iv=0, then → IDLE. No done pulses.
- Error priority: a later error overwrites err_code within the same frame.
- move_count holds its value until the next MOVE_HEADER is accepted.
- Back-to-back sections in one frame (grid then moves, no gap) are legal and require zero idle cycles between them.
- Simultaneous events: the final grid byte and the header byte on the following cycle are both accepted. No byte is ever dropped in legal streams.

Test Plan:
- Full load frame, 70 contiguous bytes, defaults:
  - Stimulus: GRID_HEADER; 64 squares (sq0 = 8'h44 white rook, sq16..47 = 8'h7F empty, sq60 = 8'h81 black king); MOVE_HEADER; bytes 01, B0, DA, 40; then spi_iv=0.
  - Required: 64 grid writes, addresses 0..63 with exact data; grid_done once, with addr 63.
  - Required: move 0 = 16'h01B0, move 1 = 16'hDA40; moves_done 1 cycle after spi_iv falls; move_count=2; err=0.
- Bad header: frame 8'h00, 8'h44 → err=1, err_code=1, no writes, busy until spi_iv=0.
- Short grid: GRID_HEADER + 10 bytes, spi_iv=0 → writes to addr 0..9, no grid_done, err_code=2. Next frame with a valid header clears err.
- Partial move: MOVE_HEADER, 01, B0, DA, spi_iv=0 → one write of 16'h01B0, move_count=1, moves_done=1, err_code=2.
- Overflow with MAX_MOVES=4: MOVE_HEADER + 5 moves → 4 writes (addr 0..3), err_code=3, no moves_done, move_count=4.
- Reset mid-grid: nrst=0 after square 20 → all outputs 0 asynchronously. A subsequent full frame loads cleanly from addr 0.
